// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared defaults and FSM encoding for the UART transmit scheduler.
package uart_tx_sched_pkg;
    localparam int UART_Q_DEPTH = 16;
    localparam int UART_TX_GAP = 8700;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_WAIT = 2'd2} tx_state_t;
endpackage

// File: rtl/sync_fifo_2w1r.sv
// sync_fifo_2w1r: byte queue with two ordered write ports and one read port.
// Lane 1 is older than lane 2, so it lands at tail and lane 2 directly behind it.
module sync_fifo_2w1r #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    we1,
    input  logic [7:0]              dat1,
    input  logic                    we2,
    input  logic [7:0]              dat2,
    input  logic                    rd,
    output logic [7:0]              rd_dat,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    accept1,
    output logic                    accept2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] free;
    // A same-cycle pop frees its slot for this cycle's pushes.
    assign free = CW'(DEPTH) - count + CW'(rd);
    assign accept1 = we1 && free != '0;
    assign accept2 = we2 && (!we1 || accept1) && free > CW'(accept1);
    assign rd_dat = mem[head];
    always_ff @(posedge clk) begin
        if (!nrst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept1) mem[tail] <= dat1;
            if (accept2) mem[tail + AW'(accept1)] <= dat2;
            head  <= head + AW'(rd);
            tail  <= tail + AW'(accept1) + AW'(accept2);
            count <= count + CW'(accept1) + CW'(accept2) - CW'(rd);
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: merges dual-lane UART stores into one queue and paces them onto the uart
// write port, one pulse every TX_GAP cycles while bytes are waiting.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH  = UART_Q_DEPTH,
    parameter int TX_GAP = UART_TX_GAP
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        we1_i,
    input  logic [7:0]  dat1_i,
    input  logic        we2_i,
    input  logic [7:0]  dat2_i,
    output logic        almost_full_o,
    output logic        empty_o,
    output logic        overflow_o,
    output logic        tx_wr_o,
    output logic [7:0]  tx_dat_o,
    output logic [15:0] sent_cnt_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(TX_GAP);
    tx_state_t state, state_nxt;
    logic [GW-1:0] gap, gap_nxt;
    logic [CW-1:0] count, count_nxt;
    logic accept1, accept2, pop, wr_nxt;
    logic [7:0] head_dat, dat_nxt;
    logic [15:0] sent_nxt;

    sync_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
        .clk(CLK), .nrst(NRST),
        .we1(we1_i), .dat1(dat1_i), .we2(we2_i), .dat2(dat2_i),
        .rd(pop), .rd_dat(head_dat),
        .count(count), .accept1(accept1), .accept2(accept2)
    );

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        wr_nxt    = 1'b0;
        dat_nxt   = tx_dat_o;
        sent_nxt  = sent_cnt_o;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: begin
                pop       = count != '0;
                wr_nxt    = pop;
                dat_nxt   = pop ? head_dat : tx_dat_o;
                state_nxt = pop ? S_SEND : S_IDLE;
            end
            S_SEND: begin
                gap_nxt   = GW'(TX_GAP - 2);
                sent_nxt  = sent_cnt_o + 16'd1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Gap expiry with bytes pending re-sends directly to keep pulses exactly TX_GAP apart.
                pop       = gap == '0 && count != '0;
                gap_nxt   = gap != '0 ? gap - GW'(1) : gap;
                wr_nxt    = pop;
                dat_nxt   = pop ? head_dat : tx_dat_o;
                state_nxt = gap != '0 ? S_WAIT : (pop ? S_SEND : S_IDLE);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign count_nxt = count + CW'(accept1) + CW'(accept2) - CW'(pop);

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state         <= S_IDLE;
            gap           <= '0;
            tx_wr_o       <= 1'b0;
            tx_dat_o      <= 8'h00;
            sent_cnt_o    <= 16'd0;
            overflow_o    <= 1'b0;
            almost_full_o <= 1'b0;
            empty_o       <= 1'b1;
        end else begin
            state         <= state_nxt;
            gap           <= gap_nxt;
            tx_wr_o       <= wr_nxt;
            tx_dat_o      <= dat_nxt;
            sent_cnt_o    <= sent_nxt;
            overflow_o    <= overflow_o | (we1_i & ~accept1) | (we2_i & ~accept2);
            almost_full_o <= CW'(DEPTH) - count_nxt < CW'(2);
            empty_o       <= count_nxt == '0;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against a queue-and-timestamp
// model: a byte leaves when the queue was non-empty and TX_GAP cycles have passed since the last pulse.
module tb_uart_tx_sched;
    localparam int DEPTH = 16;
    localparam int GAP   = 8;

    logic        CLK = 1'b0;
    logic        NRST = 1'b0;
    logic        we1 = 1'b0, we2 = 1'b0;
    logic [7:0]  dat1 = 8'h00, dat2 = 8'h00;
    logic        almost_full, empty, overflow, tx_wr;
    logic [7:0]  tx_dat;
    logic [15:0] sent_cnt;

    int total = 0;
    int bad = 0;

    uart_tx_sched #(.DEPTH(DEPTH), .TX_GAP(GAP)) dut (
        .CLK(CLK), .NRST(NRST),
        .we1_i(we1), .dat1_i(dat1), .we2_i(we2), .dat2_i(dat2),
        .almost_full_o(almost_full), .empty_o(empty), .overflow_o(overflow),
        .tx_wr_o(tx_wr), .tx_dat_o(tx_dat), .sent_cnt_o(sent_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain byte queue plus the time of the last write pulse.
    logic [7:0]  mq[$];
    logic        m_valid = 1'b0, m_has_last = 1'b0;
    logic        m_wr = 1'b0, m_af = 1'b0, m_emp = 1'b1, m_ov = 1'b0;
    logic [7:0]  m_dat = 8'h00;
    logic [15:0] m_sent = 16'd0;
    int          m_cyc = 0, m_last = 0, m_free = 0;
    logic        m_pop, m_a1, m_a2;

    always @(posedge CLK) begin
        m_cyc++;
        if (!NRST) begin
            mq.delete();
            m_has_last = 1'b0;
            m_wr = 1'b0; m_dat = 8'h00; m_sent = 16'd0;
            m_af = 1'b0; m_emp = 1'b1; m_ov = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_pop = mq.size() > 0 && (!m_has_last || m_cyc - m_last >= GAP);
            if (m_wr) m_sent = m_sent + 16'd1;
            m_free = DEPTH - mq.size() + int'(m_pop);
            m_a1 = we1 && m_free >= 1;
            m_free = m_free - int'(m_a1);
            m_a2 = we2 && m_free >= 1 && (!we1 || m_a1);
            if ((we1 && !m_a1) || (we2 && !m_a2)) m_ov = 1'b1;
            m_wr = m_pop;
            if (m_pop) begin
                m_dat = mq.pop_front();
                m_last = m_cyc;
                m_has_last = 1'b1;
            end
            if (m_a1) mq.push_back(dat1);
            if (m_a2) mq.push_back(dat2);
            m_af = DEPTH - mq.size() < 2;
            m_emp = mq.size() == 0;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("cmp_wr", 16'(tx_wr), 16'(m_wr));
            chk("cmp_dat", 16'(tx_dat), 16'(m_dat));
            chk("cmp_sent", sent_cnt, m_sent);
            chk("cmp_af", 16'(almost_full), 16'(m_af));
            chk("cmp_empty", 16'(empty), 16'(m_emp));
            chk("cmp_ovf", 16'(overflow), 16'(m_ov));
        end
    end

    task automatic cyc(input logic w1, input logic [7:0] d1, input logic w2, input logic [7:0] d2);
        we1 = w1; dat1 = d1; we2 = w2; dat2 = d2;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        NRST = 1'b0;
        repeat (n) cyc(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
        NRST = 1'b1;
    endtask

    initial begin
        logic [7:0] got[$];
        int n;
        bit found;
        int thr;

        // 1. reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cyc(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
            if (i > 0) chk("rst_wr", 16'(tx_wr), 16'd0);
        end
        chk("rst_af", 16'(almost_full), 16'd0);
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_ovf", 16'(overflow), 16'd0);
        chk("rst_dat", 16'(tx_dat), 16'h00);
        chk("rst_sent", sent_cnt, 16'd0);
        NRST = 1'b1;

        // 2. single byte latency
        cyc(1'b1, 8'h41, 1'b0, 8'h00);
        chk("single_empty_after_push", 16'(empty), 16'd0);
        chk("single_no_early_wr", 16'(tx_wr), 16'd0);
        idle(1);
        chk("single_wr", 16'(tx_wr), 16'd1);
        chk("single_dat", 16'(tx_dat), 16'h41);
        chk("single_empty", 16'(empty), 16'd1);
        idle(1);
        chk("single_wr_one_cycle", 16'(tx_wr), 16'd0);
        chk("single_sent", sent_cnt, 16'd1);
        idle(10);

        // 3. dual push in one cycle
        do_reset(1);
        cyc(1'b1, 8'h48, 1'b1, 8'h49);
        idle(1);
        chk("dual_first_wr", 16'(tx_wr), 16'd1);
        chk("dual_first_dat", 16'(tx_dat), 16'h48);
        n = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            idle(1);
            if (tx_wr) begin found = 1; n = i; end
        end
        chk("dual_gap", 16'(n), 16'(GAP));
        chk("dual_second_dat", 16'(tx_dat), 16'h49);
        idle(2);
        chk("dual_sent", sent_cnt, 16'd2);
        chk("dual_empty", 16'(empty), 16'd1);
        idle(10);

        // 4. fill to overflow, then 5. push+pop at full
        do_reset(1);
        for (int b = 0; b < 9; b++) begin
            cyc(1'b1, 8'(2 * b), 1'b1, 8'(2 * b + 1));
            if (b == 0) chk("fill_af_low", 16'(almost_full), 16'd0);
            if (b == 7) begin
                chk("fill_af_at15", 16'(almost_full), 16'd1);
                chk("fill_no_ovf_yet", 16'(overflow), 16'd0);
            end
        end
        chk("fill_ovf", 16'(overflow), 16'd1);
        chk("fill_af_full", 16'(almost_full), 16'd1);
        cyc(1'b1, 8'h20, 1'b1, 8'h21);
        chk("full_pop_wr", 16'(tx_wr), 16'd1);
        chk("full_pop_dat", 16'(tx_dat), 16'h01);
        chk("full_pop_af", 16'(almost_full), 16'd1);
        got.push_back(tx_dat);
        for (int i = 0; i < 200 && got.size() < 17; i++) begin
            idle(1);
            if (tx_wr) got.push_back(tx_dat);
        end
        chk("drain_count", 16'(got.size()), 16'd17);
        for (int i = 0; i < got.size(); i++)
            chk("drain_byte", 16'(got[i]), 16'(i < 16 ? i + 1 : 8'h20));
        idle(10);
        chk("drain_empty", 16'(empty), 16'd1);
        chk("drain_ovf_sticky", 16'(overflow), 16'd1);

        // 6. reset mid-WAIT with 5 queued
        do_reset(1);
        cyc(1'b1, 8'h01, 1'b1, 8'h02);
        cyc(1'b1, 8'h03, 1'b1, 8'h04);
        cyc(1'b1, 8'h05, 1'b0, 8'h00);
        cyc(1'b1, 8'h06, 1'b0, 8'h00);
        idle(2);
        chk("mid_pre_sent", sent_cnt, 16'd1);
        chk("mid_pre_empty", 16'(empty), 16'd0);
        NRST = 1'b0;
        idle(1);
        NRST = 1'b1;
        chk("mid_rst_empty", 16'(empty), 16'd1);
        chk("mid_rst_wr", 16'(tx_wr), 16'd0);
        chk("mid_rst_sent", sent_cnt, 16'd0);
        cyc(1'b1, 8'h5A, 1'b0, 8'h00);
        chk("mid_after_push_wr", 16'(tx_wr), 16'd0);
        idle(1);
        chk("mid_after_wr", 16'(tx_wr), 16'd1);
        chk("mid_after_dat", 16'(tx_dat), 16'h5A);

        // randomized traffic with varying density and occasional resets
        thr = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) thr = $urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) == 0 ? 4 : 13);
            NRST = $urandom_range(0, 399) != 0;
            cyc(1'($urandom_range(0, 15) < thr), 8'($urandom),
                1'($urandom_range(0, 15) < thr), 8'($urandom));
        end
        NRST = 1'b1;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
